// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for MIPS DIV/DIVU.
// Returns {remainder, quotient} as one 64-bit word for a full HI/LO write.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        stall,
  output logic        busy,
  output logic        valid,
  output logic [63:0] result,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken on the edge where start=1, cancel=0 and the
  // unit is IDLE; valid is a one-cycle pulse and result holds until the next one.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] div_q, div_d;
  logic        sign_quo_q, sign_quo_d;
  logic        sign_rem_q, sign_rem_d;
  logic        dz_q, dz_d;
  logic [63:0] result_q, result_d;
  logic        valid_q, valid_d;

  logic        accept;
  logic [31:0] mag_a, mag_b;
  logic [64:0] shifted;
  logic [32:0] rem_up, diff;
  logic [31:0] quo_fix, rem_fix;

  assign accept = start & ~cancel & (state_q == IDLE);
  assign mag_a  = (signed_div & a[31]) ? (~a + 32'd1) : a;
  assign mag_b  = (signed_div & b[31]) ? (~b + 32'd1) : b;

  // 33-bit remainder path so the compare/subtract cannot overflow.
  assign shifted = {work_q, 1'b0};
  assign rem_up  = shifted[64:32];
  assign diff    = rem_up - {1'b0, div_q};

  assign quo_fix = sign_quo_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
  assign rem_fix = sign_rem_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (b == 32'd0) ? FIX : CALC;
      CALC: begin
        if (cancel)                state_d = IDLE;
        else if (cnt_q == 5'd31)   state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != IDLE);
    stall     = accept | (state_q != IDLE);
    valid     = valid_q;
    result    = result_q;
    dbg_state = state_q;
  end

  // Datapath next-state
  always_comb begin
    cnt_d      = cnt_q;
    work_d     = work_q;
    div_d      = div_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    dz_d       = dz_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_quo_d = signed_div & (a[31] ^ b[31]);
          sign_rem_d = signed_div & a[31];
          div_d      = mag_b;
          cnt_d      = 5'd0;
          dz_d       = (b == 32'd0);
          // On divide-by-zero the raw dividend is parked here to become the remainder.
          work_d     = {32'd0, (b == 32'd0) ? a : mag_a};
        end
      end
      CALC: begin
        if (!cancel) begin
          cnt_d = cnt_q + 5'd1;
          if (rem_up >= {1'b0, div_q}) work_d = {diff[31:0], shifted[31:1], 1'b1};
          else                         work_d = shifted[63:0];
        end
      end
      FIX: begin
        if (!cancel) begin
          valid_d  = 1'b1;
          result_d = dz_q ? {work_q[31:0], 32'hFFFF_FFFF} : {rem_fix, quo_fix};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 5'd0;
      work_q     <= 64'd0;
      div_q      <= 32'd0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      dz_q       <= 1'b0;
      result_q   <= 64'd0;
      valid_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      div_q      <= div_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      dz_q       <= dz_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
    end
  end

endmodule
